// File: rtl/scandoubler_pkg.sv
// scandoubler_pkg: shared shade modes, pipeline latency and scanline shading helper.
package scandoubler_pkg;
  typedef enum logic [1:0] {SL_OFF = 2'd0, SL_25 = 2'd1, SL_50 = 2'd2, SL_75 = 2'd3} sl_mode_t;
  localparam int PIPE_LAT = 2;
  localparam int SHADE_W = 16;
  function automatic logic [SHADE_W-1:0] shade(input logic [SHADE_W-1:0] x, input sl_mode_t mode);
    return mode == SL_25 ? x - (x >> 2) : mode == SL_50 ? x >> 1 : mode == SL_75 ? x >> 2 : x;
  endfunction
endpackage

// File: rtl/scandoubler_linebuf_ram.sv
// scandoubler_linebuf_ram: simple dual-port RAM, one write port and one registered read port.
module scandoubler_linebuf_ram #(
  parameter int AW = 10,
  parameter int DW = 18
) (
  input  logic          clk_sys,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk_sys) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/scandoubler_linebuf.sv
// scandoubler_linebuf: ping-pong line buffer read twice per input line, with scanline shading and blanking.
module scandoubler_linebuf
  import scandoubler_pkg::*;
#(
  parameter int HCNT_WIDTH  = 9,
  parameter int LINE_LEN    = 512,
  parameter int COLOR_DEPTH = 6
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   pe_in,
  input  logic [HCNT_WIDTH-1:0]  hcnt_in,
  input  logic                   line_in,
  input  logic [COLOR_DEPTH-1:0] r_in,
  input  logic [COLOR_DEPTH-1:0] g_in,
  input  logic [COLOR_DEPTH-1:0] b_in,
  input  logic                   pe_out,
  input  logic [HCNT_WIDTH-1:0]  hcnt_out,
  input  logic                   hb_out,
  input  logic                   vb_out,
  input  logic                   hs_out,
  input  logic                   vs_out,
  input  logic [1:0]             scanlines,
  output logic [COLOR_DEPTH-1:0] r_out,
  output logic [COLOR_DEPTH-1:0] g_out,
  output logic [COLOR_DEPTH-1:0] b_out,
  output logic                   hb_d,
  output logic                   vb_d,
  output logic                   hs_d,
  output logic                   vs_d
);
  localparam int DW = 3 * COLOR_DEPTH;
  localparam logic [HCNT_WIDTH:0] LEN = (HCNT_WIDTH + 1)'(LINE_LEN);
  logic line_q, odd, first, v1, rng1, odd1;
  logic odd_n, first_n, line_chg, hz, in_ok, kill;
  logic [DW-1:0] rdata;
  logic [PIPE_LAT-1:0][3:0] fr_sr;
  logic [COLOR_DEPTH-1:0] r_s, g_s, b_s;
  sl_mode_t mode;
  assign in_ok = {1'b0, hcnt_in} < LEN;
  scandoubler_linebuf_ram #(.AW(HCNT_WIDTH + 1), .DW(DW)) u_ram (
    .clk_sys (clk_sys),
    .we      (pe_in && in_ok),
    .waddr   ({line_in, hcnt_in}),
    .wdata   ({r_in, g_in, b_in}),
    .re      (pe_out),
    .raddr   ({~line_q, hcnt_out}),
    .rdata   (rdata)
  );
  // the first hcnt_out==0 after a bank switch starts the even line, so it must not toggle
  always_comb begin
    line_chg = line_in != line_q;
    hz = pe_out && hcnt_out == '0;
    odd_n = line_chg ? 1'b0 : (hz && !first) ? ~odd : odd;
    first_n = line_chg ? 1'b1 : hz ? 1'b0 : first;
    mode = odd1 ? sl_mode_t'(scanlines) : SL_OFF;
    r_s = COLOR_DEPTH'(shade(SHADE_W'(rdata[DW-1 -: COLOR_DEPTH]), mode));
    g_s = COLOR_DEPTH'(shade(SHADE_W'(rdata[2*COLOR_DEPTH-1 -: COLOR_DEPTH]), mode));
    b_s = COLOR_DEPTH'(shade(SHADE_W'(rdata[COLOR_DEPTH-1:0]), mode));
    kill = fr_sr[0][3] | fr_sr[0][2] | !rng1;
  end
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      line_q <= 1'b0;
      odd <= 1'b0;
      first <= 1'b1;
      v1 <= 1'b0;
      rng1 <= 1'b0;
      odd1 <= 1'b0;
      fr_sr <= '0;
      {r_out, g_out, b_out} <= '0;
    end else begin
      line_q <= line_in;
      odd <= odd_n;
      first <= first_n;
      v1 <= pe_out;
      if (pe_out) rng1 <= {1'b0, hcnt_out} < LEN;
      if (pe_out) odd1 <= odd_n;
      fr_sr <= {fr_sr[PIPE_LAT-2:0], {hb_out, vb_out, hs_out, vs_out}};
      if (v1) {r_out, g_out, b_out} <= kill ? '0 : {r_s, g_s, b_s};
    end
  end
  assign {hb_d, vb_d, hs_d, vs_d} = fr_sr[PIPE_LAT-1];
endmodule

// File: tb/tb_scandoubler_linebuf.sv
// tb_scandoubler_linebuf: directed checks of buffering, shading, blanking, range limit and reset.
module tb_scandoubler_linebuf;
  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic pe_in = 1'b0, line_in = 1'b0, pe_out = 1'b0;
  logic [8:0] hcnt_in = '0, hcnt_out = '0;
  logic [5:0] r_in = '0, g_in = '0, b_in = '0;
  logic hb_out = 1'b0, vb_out = 1'b0, hs_out = 1'b0, vs_out = 1'b0;
  logic [1:0] scanlines = 2'd0;
  logic [5:0] r_out, g_out, b_out;
  logic hb_d, vb_d, hs_d, vs_d;
  int tests = 0;
  int fails = 0;
  scandoubler_linebuf #(.HCNT_WIDTH(9), .LINE_LEN(320), .COLOR_DEPTH(6)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .pe_in(pe_in), .hcnt_in(hcnt_in), .line_in(line_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .pe_out(pe_out), .hcnt_out(hcnt_out),
    .hb_out(hb_out), .vb_out(vb_out), .hs_out(hs_out), .vs_out(vs_out), .scanlines(scanlines),
    .r_out(r_out), .g_out(g_out), .b_out(b_out), .hb_d(hb_d), .vb_d(vb_d), .hs_d(hs_d), .vs_d(vs_d)
  );
  always #5 clk_sys = ~clk_sys;
  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [8:0] a, input logic [5:0] v);
    pe_in = 1'b1; hcnt_in = a; r_in = v; g_in = v; b_in = v;
    tick;
    pe_in = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [8:0] a, input logic [5:0] e);
    pe_out = 1'b1; hcnt_out = a;
    tick;
    pe_out = 1'b0;
    tick;
    check(tag, 32'({r_out, g_out, b_out}), 32'({e, e, e}));
  endtask
  initial begin
    logic [8:0] seq [10];
    logic [5:0] exp [10];
    seq = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    exp = '{8, 12, 16, 20, 24, 28, 32, 36, 4, 6};
    tick; tick;
    check("rst_rgb", 32'({r_out, g_out, b_out}), 32'd0);
    check("rst_sync", 32'({hb_d, vb_d, hs_d, vs_d}), 32'd0);
    reset_n = 1'b1;
    tick;
    for (int i = 0; i < 16; i++) wr(9'(i), 6'(i));
    line_in = 1'b1;
    tick;
    pe_out = 1'b1; hcnt_out = 9'd5;
    tick;
    pe_out = 1'b0;
    check("lat1", 32'({r_out, g_out, b_out}), 32'd0);
    tick;
    check("basic", 32'({r_out, g_out, b_out}), 32'({6'd5, 6'd5, 6'd5}));
    wr(0, 40); wr(1, 40); wr(2, 40); wr(3, 63);
    line_in = 1'b0;
    tick;
    scanlines = 2'd2;
    rd("sl_even50", 0, 40);
    rd("sl_odd50", 0, 20);
    scanlines = 2'd1;
    rd("sl_odd25", 1, 30);
    scanlines = 2'd3;
    rd("sl_odd75", 2, 10);
    scanlines = 2'd0;
    rd("sl_odd0", 1, 40);
    scanlines = 2'd3;
    rd("sl_even75", 0, 40);
    scanlines = 2'd0;
    hb_out = 1'b1; vs_out = 1'b1; pe_out = 1'b1; hcnt_out = 9'd3;
    tick;
    hb_out = 1'b0; vs_out = 1'b0; pe_out = 1'b0;
    check("hb_d_early", 32'(hb_d), 32'd0);
    tick;
    check("hb_d_rise", 32'(hb_d), 32'd1);
    check("vs_d_rise", 32'(vs_d), 32'd1);
    check("blank_rgb", 32'({r_out, g_out, b_out}), 32'd0);
    tick;
    check("hb_d_fall", 32'(hb_d), 32'd0);
    rd("noblank", 3, 63);
    wr(319, 50); wr(320, 33); wr(330, 33);
    for (int i = 0; i < 8; i++) wr(9'(i), 6'(8 + 4 * i));
    line_in = 1'b1;
    tick;
    rd("rng319", 319, 50);
    rd("rng320", 320, 0);
    rd("rng330", 330, 0);
    scanlines = 2'd2;
    for (int t = 0; t <= 10; t++) begin
      if (t < 10) begin
        pe_out = 1'b1; hcnt_out = seq[t];
      end else pe_out = 1'b0;
      tick;
      if (t >= 1) check($sformatf("div1_%0d", t - 1), 32'({r_out, g_out, b_out}), 32'({exp[t-1], exp[t-1], exp[t-1]}));
    end
    hs_out = 1'b1;
    tick; tick;
    check("hs_d_pre", 32'(hs_d), 32'd1);
    pe_out = 1'b1; hcnt_out = 9'd2;
    tick;
    reset_n = 1'b0; line_in = 1'b0;
    #1;
    check("async_rgb", 32'({r_out, g_out, b_out}), 32'd0);
    check("async_hs", 32'(hs_d), 32'd0);
    pe_out = 1'b0; hs_out = 1'b0;
    tick; tick;
    reset_n = 1'b1;
    tick;
    rd("rst_even", 0, 40);
    rd("rst_odd", 0, 20);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
